// File: rtl/mmio_pkg.sv
// Shared opcode constants, FSM state type and defaults for the MMIO sequencer.
package mmio_pkg;

    localparam logic [2:0] OP_WR0  = 3'd0;
    localparam logic [2:0] OP_WR1  = 3'd1;
    localparam logic [2:0] OP_RD0  = 3'd2;
    localparam logic [2:0] OP_RD1  = 3'd3;
    localparam logic [2:0] OP_NONE = 3'd4;

    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_valid_op(input logic [2:0] op);
        return op <= OP_RD1;
    endfunction

    function automatic logic is_write_op(input logic [2:0] op);
        return op < OP_RD0;
    endfunction

endpackage

// File: rtl/mmio_seq_ctrl_if.sv
// CPU-side and peripheral-side signal bundle of the MMIO sequencer.
interface mmio_seq_ctrl_if;

    logic [2:0]  opcode;
    logic        start;
    logic [31:0] wdata;
    logic        stall;
    logic        per_req;
    logic [1:0]  per_sel;
    logic        per_we;
    logic [31:0] per_wdata;
    logic        per_ack;
    logic [31:0] per_rdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;

    modport master (
        output opcode, start, wdata, per_ack, per_rdata,
        input  stall, per_req, per_sel, per_we, per_wdata,
        input  rdata, rdata_valid, err
    );

    modport slave (
        input  opcode, start, wdata, per_ack, per_rdata,
        output stall, per_req, per_sel, per_we, per_wdata,
        output rdata, rdata_valid, err
    );

endinterface

// File: rtl/mmio_timer.sv
// REQ-state watchdog counter; expired flags the last allowed REQ cycle.
module mmio_timer (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // count holds the number of REQ cycles already completed
    assign expired = enable && (count == limit - 8'd1);

endmodule

// File: rtl/mmio_seq_ctrl.sv
// MMIO request sequencer: IDLE -> REQ -> DONE handshake toward one peripheral.
// Optional REQ watchdog enabled by defining MMIO_TIMEOUT_EN.
module mmio_seq_ctrl
    import mmio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input logic            clk,
    input logic            rstn,
    mmio_seq_ctrl_if.slave bus
);

    state_e      state_q;
    state_e      state_d;
    logic [2:0]  op_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic        in_req;
    logic        expired;

    assign in_req = (state_q == REQ);
    assign accept = rstn && (state_q == IDLE) && bus.start && is_valid_op(bus.opcode);

`ifdef MMIO_TIMEOUT_EN
    logic err_q;

    mmio_timer u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (accept),
        .enable  (in_req),
        .limit   (8'(TIMEOUT_CYCLES)),
        .expired (expired)
    );

    // ack in the expiring cycle still counts as a normal completion
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (in_req && expired && !bus.per_ack) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign expired = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ:  if (bus.per_ack || expired) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q    <= 3'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            op_q    <= bus.opcode;
            wdata_q <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= 32'd0;
        end else if (in_req && !is_write_op(op_q)) begin
            unique case (1'b1)
                bus.per_ack: rdata_q <= bus.per_rdata;
                expired:     rdata_q <= 32'hFFFF_FFFF;
                default:     rdata_q <= rdata_q;
            endcase
        end
    end

    assign bus.stall       = accept || in_req;
    assign bus.per_req     = in_req;
    assign bus.per_sel     = in_req ? op_q[1:0] : 2'b00;
    assign bus.per_we      = in_req && is_write_op(op_q);
    assign bus.per_wdata   = in_req ? wdata_q : 32'd0;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = (state_q == DONE);

endmodule
